pe_out_collector: RTL and testbench

Collects the alpha-output stream of one PE and presents whole frames to the downstream consumer. A frame is OUT_NUM bursts (blocks) of ALPHA_NUM complex words separated by idle gaps. Frames are checked, double-buffered in a 2-bank RAM and streamed out on a valid/ready interface with a frame-end marker. The collector sits between a PE's dout_pe_v/dout_pe pair and the array output mux or host DMA.

---
 rtl/pe_out_collector_pkg.sv | 19 +
 rtl/collect_ram.sv | 27 ++
 rtl/pe_out_collector.sv | 254 +++++++++++++++++++++++++
 tb/tb_pe_out_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_out_collector_pkg.sv
// Shared defaults, write-FSM state encodings and sizing helper for the PE output collector.
package pe_out_collector_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ALPHA_NUM_DEF  = 8;
  localparam int OUT_NUM_DEF    = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BLK     = 3'd1;
  localparam logic [2:0] ST_GAP     = 3'd2;
  localparam logic [2:0] ST_DROP    = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  // Counter/address width that stays legal (>= 1 bit) for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/collect_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read with one cycle of latency.
module collect_ram
  import pe_out_collector_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; bank_full/pend in the top decide what is valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pe_out_collector.sv
// Checks a PE's burst output stream into whole frames, double-buffers them and streams them out on valid/ready.
module pe_out_collector
  import pe_out_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ALPHA_NUM  = ALPHA_NUM_DEF,
  parameter int OUT_NUM    = OUT_NUM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_v,
  input  logic [2*DATA_WIDTH-1:0] din,
  output logic                    m_valid,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    err_len,
  output logic                    ovf,
  output logic [15:0]             frame_cnt
);

  localparam int WORD_W  = 2 * DATA_WIDTH;
  localparam int FRAME   = ALPHA_NUM * OUT_NUM;
  localparam int ADDR_W  = cnt_width(2 * FRAME);
  localparam int ALPHA_W = cnt_width(ALPHA_NUM);
  localparam int BLK_W   = cnt_width(OUT_NUM);
  localparam int IDX_W   = cnt_width(FRAME);

  localparam logic [ALPHA_W-1:0] ALPHA_LAST = ALPHA_W'(ALPHA_NUM - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(OUT_NUM - 1);
  localparam logic [IDX_W-1:0]   FRAME_LAST = IDX_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0]  BANK1_BASE = ADDR_W'(FRAME);

  // ---------------------------------------------------------------- write side
  logic [2:0]         state, state_n;
  logic [ALPHA_W-1:0] alpha_cnt, alpha_n;
  logic [BLK_W-1:0]   blk_cnt, blk_n;
  logic [IDX_W-1:0]   disc_cnt, disc_n;
  logic               gap_first, gap_first_n;
  logic               wr_bank;
  logic [1:0]         bank_full, bank_full_n;
  logic               bank_free, accept, wr_en, commit, err_set, ovf_set;
  logic [ADDR_W-1:0]  wr_addr;

  // ----------------------------------------------------------------- read side
  logic               pop, free_fire, issue, idx_last;
  logic [1:0]         occ, pend, pend_n, level;
  logic               inflight, inflight_last;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_bank, free_bank;
  logic [ADDR_W-1:0]  rd_addr;
  logic [WORD_W-1:0]  ram_q, skid_data;
  logic               skid_last;

  assign pop       = m_valid & m_ready;
  assign free_fire = pop & m_last;
  // A bank whose last word is being accepted this cycle is already free for a new frame.
  assign bank_free = !bank_full[wr_bank] || (free_fire && (free_bank == wr_bank));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    alpha_n     = alpha_cnt;
    blk_n       = blk_cnt;
    disc_n      = disc_cnt;
    gap_first_n = gap_first;
    accept      = 1'b0;
    commit      = 1'b0;
    err_set     = 1'b0;
    ovf_set     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (din_v) begin
          if (bank_free) begin
            accept = 1'b1;
          end else begin
            ovf_set = 1'b1;
            disc_n  = IDX_W'(1);
            state_n = ST_DISCARD;
          end
        end
      end
      ST_BLK: begin
        if (din_v) begin
          accept = 1'b1;
        end else begin
          err_set = 1'b1;
          alpha_n = '0;
          blk_n   = '0;
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!din_v) begin
          gap_first_n = 1'b0;
        end else if (gap_first) begin
          // A word right after the block end means the block ran long.
          err_set = 1'b1;
          alpha_n = '0;
          blk_n   = '0;
          state_n = ST_DROP;
        end else begin
          accept = 1'b1;
        end
      end
      ST_DROP: begin
        if (!din_v) state_n = ST_IDLE;
      end
      ST_DISCARD: begin
        if (din_v) begin
          if (disc_cnt == FRAME_LAST) begin
            disc_n  = '0;
            state_n = ST_IDLE;
          end else begin
            disc_n = disc_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (accept) begin
      if (alpha_cnt == ALPHA_LAST) begin
        alpha_n = '0;
        if (blk_cnt == BLK_LAST) begin
          commit  = 1'b1;
          blk_n   = '0;
          state_n = ST_IDLE;
        end else begin
          blk_n       = blk_cnt + 1'b1;
          gap_first_n = 1'b1;
          state_n     = ST_GAP;
        end
      end else begin
        alpha_n = alpha_cnt + 1'b1;
        state_n = ST_BLK;
      end
    end
  end

  assign wr_en   = accept;
  assign wr_addr = (wr_bank ? BANK1_BASE : '0)
                 + ADDR_W'(blk_cnt) * ADDR_W'(ALPHA_NUM)
                 + ADDR_W'(alpha_cnt);

  // Commit of one bank and release of the other can land on the same edge.
  always_comb begin
    bank_full_n = bank_full;
    if (free_fire) bank_full_n[free_bank] = 1'b0;
    if (commit)    bank_full_n[wr_bank]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      alpha_cnt <= '0;
      blk_cnt   <= '0;
      disc_cnt  <= '0;
      gap_first <= 1'b0;
      wr_bank   <= 1'b0;
      bank_full <= '0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      alpha_cnt <= alpha_n;
      blk_cnt   <= blk_n;
      disc_cnt  <= disc_n;
      gap_first <= gap_first_n;
      bank_full <= bank_full_n;
      err_len   <= err_set;
      ovf       <= ovf_set;
      if (commit) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // ----------------------------------------------------------- read pipeline
  // Reads are issued only while the 2-entry output queue plus the RAM word in flight stays within 2.
  assign level    = occ + {1'b0, inflight} - {1'b0, pop};
  assign idx_last = (rd_idx == FRAME_LAST);
  assign issue    = (pend != 2'd0) && (level < 2'd2);
  assign rd_addr  = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(rd_idx);
  assign pend_n   = pend + {1'b0, commit} - {1'b0, issue & idx_last};
  assign m_valid  = (occ != 2'd0);

  collect_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (2 * FRAME),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (din),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      occ           <= '0;
      pend          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_idx        <= '0;
      rd_bank       <= 1'b0;
      free_bank     <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else begin
      pend          <= pend_n;
      inflight      <= issue;
      inflight_last <= issue & idx_last;
      occ           <= level;
      if (issue) begin
        rd_idx <= idx_last ? '0 : rd_idx + 1'b1;
        if (idx_last) rd_bank <= ~rd_bank;
      end
      if (free_fire) free_bank <= ~free_bank;

      // Head entry drives m_data/m_last and only changes when popped or when empty.
      if (pop) begin
        if (occ == 2'd2) begin
          m_data <= skid_data;
          m_last <= skid_last;
          if (inflight) begin
            skid_data <= ram_q;
            skid_last <= inflight_last;
          end
        end else if (inflight) begin
          m_data <= ram_q;
          m_last <= inflight_last;
        end
      end else if (inflight) begin
        if (occ == 2'd0) begin
          m_data <= ram_q;
          m_last <= inflight_last;
        end else begin
          skid_data <= ram_q;
          skid_last <= inflight_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_out_collector.sv
// Scoreboard bench for pe_out_collector: directed frames push expected words, a negedge monitor pops and compares.
module tb_pe_out_collector;

  localparam int AN    = 8;
  localparam int ON    = 4;
  localparam int FRAME = AN * ON;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_v = 1'b0;
  logic [31:0] din = '0;
  logic        m_valid, m_last, err_len, ovf;
  logic [31:0] m_data;
  logic        m_ready = 1'b1;
  logic [15:0] frame_cnt;

  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_err = 0;
  int n_ovf = 0;
  int rmode = 0;

  always #5 clk = ~clk;

  pe_out_collector #(
    .DATA_WIDTH (16),
    .ALPHA_NUM  (AN),
    .OUT_NUM    (ON)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_v     (din_v),
    .din       (din),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .err_len   (err_len),
    .ovf       (ovf),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // m_ready pattern: 0 = always high, 1 = toggle every cycle, 2 = held low.
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  // Monitor: pulse counting, stall stability and in-order scoreboard compare.
  initial begin
    logic        held = 1'b0;
    logic [32:0] held_word = '0;
    logic [32:0] exp_word;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (err_len) n_err++;
        if (ovf) n_ovf++;
        if (!m_valid) begin
          held = 1'b0;
        end else begin
          if (held) check("stall_stable", {m_last, m_data}, held_word);
          if (m_ready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_out: got %0h expected none at %0t", {m_last, m_data}, $time);
            end else begin
              exp_word = exp_q.pop_front();
              check("out_word", {m_last, m_data}, exp_word);
            end
          end else begin
            held      = 1'b1;
            held_word = {m_last, m_data};
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_v = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_block(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      din_v = 1'b1;
      din   = 32'(base + i);
      tick();
    end
    din_v = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int b = 0; b < ON; b++) begin
      send_block(base + b * AN, AN);
      if (b < ON - 1) idle(3);
    end
  endtask

  task automatic expect_frame(input int base);
    for (int i = 0; i < FRAME; i++) exp_q.push_back({(i == FRAME - 1), 32'(base + i)});
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    din_v = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int e0, o0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_err_len", err_len, 0);
    check("rst_ovf", ovf, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Single frame, ready high: output appears two edges after the last input word.
    expect_frame(0);
    send_frame(0);
    check("single_frame_cnt", frame_cnt, 1);
    check("lat_t0_valid", m_valid, 0);
    tick();
    check("lat_t1_valid", m_valid, 0);
    tick();
    check("lat_t2_valid", m_valid, 1);
    wait_drain(200);

    // Back-pressure: ready toggles every cycle.
    do_reset();
    rmode = 1;
    expect_frame(0);
    send_frame(0);
    wait_drain(400);
    check("bp_frame_cnt", frame_cnt, 1);
    rmode = 0;

    // Short third block: frame dropped, following frame intact.
    do_reset();
    e0 = n_err;
    send_block(0, AN);
    idle(3);
    send_block(8, AN);
    idle(3);
    send_block(16, 5);
    idle(5);
    check("short_err_cnt", 64'(n_err - e0), 1);
    check("short_frame_cnt", frame_cnt, 0);
    expect_frame(100);
    send_frame(100);
    wait_drain(200);
    check("short_next_cnt", frame_cnt, 1);
    check("short_err_once", 64'(n_err - e0), 1);

    // Nine consecutive words: long block, burst dropped.
    do_reset();
    e0 = n_err;
    send_block(0, AN + 1);
    idle(4);
    check("nogap_err_cnt", 64'(n_err - e0), 1);
    check("nogap_frame_cnt", frame_cnt, 0);
    expect_frame(500);
    send_frame(500);
    wait_drain(200);
    check("nogap_next_cnt", frame_cnt, 1);

    // Overflow: consumer stalled, third frame has no bank.
    do_reset();
    rmode = 2;
    tick();
    o0 = n_ovf;
    expect_frame(200);
    send_frame(200);
    idle(3);
    expect_frame(300);
    send_frame(300);
    idle(3);
    send_frame(400);
    idle(3);
    check("ovf_cnt", 64'(n_ovf - o0), 1);
    check("ovf_frame_cnt", frame_cnt, 2);
    check("ovf_stalled_valid", m_valid, 1);
    rmode = 0;
    wait_drain(400);
    check("ovf_final_cnt", frame_cnt, 2);

    // Reset after 12 words of a frame, then a clean frame.
    do_reset();
    send_block(600, AN);
    idle(3);
    send_block(608, 4);
    rst = 1'b1;
    tick();
    check("midrst_valid", m_valid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick();
    expect_frame(700);
    send_frame(700);
    wait_drain(200);
    check("midrst_next_cnt", frame_cnt, 1);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
